// File: rtl/dfs_freq_arbiter_pkg.sv
// Shared types and helpers for the DFS frequency-request arbiter.
package dfs_arb_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    WAIT_UNLOCK,
    WAIT_LOCK,
    SETTLE,
    ACK
  } state_t;

  localparam int FREQ_W_DEF = 8;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_sat(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/dfs_freq_arbiter_if.sv
// Requester, clock-manager and status signals of the DFS arbiter; master is the arbiter side.
interface dfs_freq_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int FREQ_W = dfs_arb_pkg::FREQ_W_DEF
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*FREQ_W-1:0] req_freq_i;
  logic [N_REQ-1:0]        req_ack_o;
  logic [FREQ_W-1:0]       freq_data_o;
  logic                    freq_valid_o;
  logic                    mmcm_locked_i;
  logic [FREQ_W-1:0]       cur_freq_o;
  logic                    busy_o;
  logic                    err_o;

  modport master (
    input  req_valid_i, req_freq_i, mmcm_locked_i,
    output req_ack_o, freq_data_o, freq_valid_o, cur_freq_o, busy_o, err_o
  );

  modport slave (
    output req_valid_i, req_freq_i, mmcm_locked_i,
    input  req_ack_o, freq_data_o, freq_valid_o, cur_freq_o, busy_o, err_o
  );
endinterface

// File: rtl/dfs_freq_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping modulo N_REQ.
module dfs_rr_arbiter
  import dfs_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2_sat(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  int idx;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx]) begin
        gnt_oh_o      = '0;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = IDX_W'(idx);
        gnt_valid_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfs_freq_arbiter.sv
// Round-robin sharing of the clock manager's DFS request port with unlock/relock/settle sequencing.
// Define DFS_ARB_TIMEOUT_EN to bound WAIT_LOCK and raise a sticky err_o on expiry.
module dfs_freq_arbiter
  import dfs_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int FREQ_W        = FREQ_W_DEF,
  parameter int RESET_FREQ    = 0,
  parameter int UNLOCK_WINDOW = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input  logic               clk_in,
  input  logic               rst_in,
  dfs_freq_arbiter_if.master bus
);

  localparam int IDX_W   = clog2_sat(N_REQ);
  localparam int MAX_US  = (UNLOCK_WINDOW > SETTLE_CYCLES) ? UNLOCK_WINDOW : SETTLE_CYCLES;
  localparam int CNT_MAX = (MAX_US > LOCK_TIMEOUT) ? MAX_US : LOCK_TIMEOUT;
  localparam int CNT_W   = clog2_sat(CNT_MAX);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_WINDOW - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef DFS_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  logic err_q;
`endif

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [N_REQ-1:0]   grant_oh_q;
  logic [FREQ_W-1:0]  data_q;
  logic [FREQ_W-1:0]  freq_data_q;
  logic               freq_valid_q;
  logic [N_REQ-1:0]   req_ack_q;
  logic [FREQ_W-1:0]  cur_freq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_sat_d;

  logic [N_REQ-1:0]   gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic [FREQ_W-1:0]  req_data;

  dfs_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i       (bus.req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_oh_o    (gnt_oh),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign req_data  = bus.req_freq_i[int'(gnt_idx)*FREQ_W +: FREQ_W];
  assign cnt_sat_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      grant_oh_q   <= '0;
      data_q       <= '0;
      freq_data_q  <= '0;
      freq_valid_q <= 1'b0;
      req_ack_q    <= '0;
      cur_freq_q   <= FREQ_W'(RESET_FREQ);
      cnt_q        <= '0;
`ifdef DFS_ARB_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      freq_valid_q <= 1'b0;
      req_ack_q    <= '0;
      case (state_q)
        INIT: if (bus.mmcm_locked_i) state_q <= IDLE;
        // The cycle the ack is visible is still IDLE; hold off so the served requester can drop.
        IDLE: begin
          if (!bus.mmcm_locked_i) begin
            state_q <= INIT;
          end else if (gnt_valid && req_ack_q == '0) begin
            grant_oh_q <= gnt_oh;
            data_q     <= req_data;
            ptr_q      <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            if (req_data == cur_freq_q) begin
              state_q <= ACK;
            end else begin
              state_q      <= ISSUE;
              freq_valid_q <= 1'b1;
              freq_data_q  <= req_data;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT_UNLOCK;
          cnt_q   <= '0;
        end
        WAIT_UNLOCK: begin
          if (!bus.mmcm_locked_i) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == UNLOCK_LAST) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        WAIT_LOCK: begin
          if (bus.mmcm_locked_i) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
`ifdef DFS_ARB_TIMEOUT_EN
          end else if (cnt_q == TIMEOUT_LAST) begin
            err_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_sat_d;
`endif
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cur_freq_q <= data_q;
            state_q    <= ACK;
          end else begin
            cnt_q <= cnt_sat_d;
          end
        end
        ACK: begin
          req_ack_q <= grant_oh_q;
          state_q   <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign bus.req_ack_o    = req_ack_q;
  assign bus.freq_data_o  = freq_data_q;
  assign bus.freq_valid_o = freq_valid_q;
  assign bus.cur_freq_o   = cur_freq_q;
  assign bus.busy_o       = (state_q != IDLE);
`ifdef DFS_ARB_TIMEOUT_EN
  assign bus.err_o        = err_q;
`else
  assign bus.err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_dfs_freq_arbiter.sv
// Self-checking bench for dfs_freq_arbiter: requester/clock-manager models plus issue/ack scoreboards.
module tb_dfs_freq_arbiter;

  localparam int N  = 4;
  localparam int FW = 8;
  localparam int UW = 64;
  localparam int SC = 16;
  localparam int LT = 4096;

  typedef enum int {LK_OFF, LK_DROP, LK_HOLD, LK_STUCK} lk_t;

  typedef struct {
    int         req;
    logic [7:0] freq;
    lk_t        mode;
    bit         exp_issue;
    logic [7:0] exp_cur;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  dfs_freq_arbiter_if #(.N_REQ(N), .FREQ_W(FW)) bus ();

  dfs_freq_arbiter #(
    .N_REQ(N), .FREQ_W(FW), .RESET_FREQ(0),
    .UNLOCK_WINDOW(UW), .SETTLE_CYCLES(SC), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_freq_q[$];
  int            exp_ack_q[$];
  int ack_total = 0, issue_total = 0, outstanding = 0;
  int last_issue_cyc = 0, last_ack_cyc = 0, relock_cyc = 0, err_rise_cyc = -1;
  lk_t lk_mode = LK_OFF;
  int  lk_hold = 0;
  bit  lk_stuck = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs, score them, then update the requester and clock-manager models.
  task automatic tick();
    int r;
    @(negedge clk_in);
    if (bus.freq_valid_o === 1'b1) begin
      issue_total++;
      last_issue_cyc = cyc;
      check("ack_before_next_issue", outstanding, 0);
      if (exp_freq_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_issue: got data %0d, expected no issue", bus.freq_data_o);
      end else begin
        check("issue_data", bus.freq_data_o, exp_freq_q.pop_front());
      end
      outstanding = 1;
    end
    if (bus.req_ack_o !== '0) begin
      ack_total++;
      last_ack_cyc = cyc;
      outstanding = 0;
      if (exp_ack_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_ack: got %b, expected none", bus.req_ack_o);
      end else begin
        r = exp_ack_q.pop_front();
        check("ack_onehot", bus.req_ack_o, 32'(1) << r);
      end
      bus.req_valid_i = bus.req_valid_i & ~bus.req_ack_o;
    end
    if (bus.err_o === 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc;
    if (lk_mode == LK_OFF) begin
      bus.mmcm_locked_i = 1'b0;
      lk_hold = 0;
      lk_stuck = 1'b0;
    end else if (lk_hold > 0) begin
      lk_hold--;
      if (lk_hold == 0) begin
        bus.mmcm_locked_i = 1'b1;
        relock_cyc = cyc + 1;  // first cycle in which the arbiter has sampled the lock
      end
    end else if (lk_stuck) begin
      bus.mmcm_locked_i = 1'b0;
    end else if (bus.freq_valid_o === 1'b1 && lk_mode == LK_DROP) begin
      bus.mmcm_locked_i = 1'b0;
      lk_hold = 20;
    end else if (bus.freq_valid_o === 1'b1 && lk_mode == LK_STUCK) begin
      bus.mmcm_locked_i = 1'b0;
      lk_stuck = 1'b1;
    end else begin
      bus.mmcm_locked_i = 1'b1;
    end
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_total < target && n < budget) begin
      tick();
      n++;
    end
    check({name, "_ack_seen"}, ack_total, target);
  endtask

  task automatic drive(input int r, input logic [FW-1:0] f, input bit issue);
    bus.req_freq_i[r*FW +: FW] = f;
    bus.req_valid_i[r] = 1'b1;
    exp_ack_q.push_back(r);
    if (issue) exp_freq_q.push_back(f);
  endtask

  vec_t vecs[5];

  initial begin
    int drive_cyc, acks0, issues0, n;
    vecs[0] = '{req: 3, freq: 8'd40,  mode: LK_DROP, exp_issue: 1'b1, exp_cur: 8'd40};
    vecs[1] = '{req: 1, freq: 8'd40,  mode: LK_HOLD, exp_issue: 1'b0, exp_cur: 8'd40};
    vecs[2] = '{req: 0, freq: 8'd7,   mode: LK_HOLD, exp_issue: 1'b1, exp_cur: 8'd7};
    vecs[3] = '{req: 2, freq: 8'd7,   mode: LK_DROP, exp_issue: 1'b0, exp_cur: 8'd7};
    vecs[4] = '{req: 3, freq: 8'd255, mode: LK_DROP, exp_issue: 1'b1, exp_cur: 8'd255};

    bus.req_valid_i   = '0;
    bus.req_freq_i    = '0;
    bus.mmcm_locked_i = 1'b0;
    #1 rst_in = 1'b0;
    repeat (3) tick();
    check("rst_freq_valid", bus.freq_valid_o, 0);
    check("rst_freq_data",  bus.freq_data_o, 0);
    check("rst_ack",        bus.req_ack_o, 0);
    check("rst_cur_freq",   bus.cur_freq_o, 0);
    check("rst_busy",       bus.busy_o, 1);
    check("rst_err",        bus.err_o, 0);

    // Request before lock: nothing may be granted while INIT waits.
    rst_in = 1'b1;
    drive(0, 8'd12, 1'b1);
    repeat (10) tick();
    check("prelock_issues", issue_total, 0);
    check("prelock_acks",   ack_total, 0);
    check("prelock_busy",   bus.busy_o, 1);
    lk_mode = LK_DROP;
    wait_acks(1, 200, "first");
    check("first_ack_vs_relock", last_ack_cyc - relock_cyc, SC + 1);
    check("first_cur_freq", bus.cur_freq_o, 12);
    check("first_issue_count", issue_total, 1);

    // Same index as current: acked without touching the clock manager.
    tick();
    drive_cyc = cyc;
    drive(2, 8'd12, 1'b0);
    wait_acks(2, 50, "same");
    check("same_ack_latency", last_ack_cyc - drive_cyc, 2);
    check("same_issue_count", issue_total, 1);

    for (int i = 0; i < 5; i++) begin
      tick();
      lk_mode   = vecs[i].mode;
      drive_cyc = cyc;
      issues0   = issue_total;
      drive(vecs[i].req, vecs[i].freq, vecs[i].exp_issue);
      wait_acks(ack_total + 1, 300, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_cur", i), bus.cur_freq_o, vecs[i].exp_cur);
      if (!vecs[i].exp_issue)
        check($sformatf("vec%0d_ack_lat", i), last_ack_cyc - drive_cyc, 2);
      else if (vecs[i].mode == LK_HOLD)
        check($sformatf("vec%0d_ack_lat", i), last_ack_cyc - last_issue_cyc, UW + SC + 2);
      else
        check($sformatf("vec%0d_ack_lat", i), last_ack_cyc - relock_cyc, SC + 1);
      check($sformatf("vec%0d_issues", i), issue_total - issues0, int'(vecs[i].exp_issue));
    end

    // All four at once with the pointer back at 0: served 0,1,2,3.
    tick();
    lk_mode = LK_DROP;
    acks0 = ack_total;
    drive(0, 8'd3, 1'b1);
    drive(1, 8'd5, 1'b1);
    drive(2, 8'd7, 1'b1);
    drive(3, 8'd9, 1'b1);
    wait_acks(acks0 + 4, 800, "rr4");
    check("rr4_cur", bus.cur_freq_o, 9);

    // Pointer wrapped to 0: requester 0 wins over 3.
    tick();
    acks0 = ack_total;
    drive(0, 8'd21, 1'b1);
    drive(3, 8'd20, 1'b1);
    wait_acks(acks0 + 2, 400, "ptr0");
    check("ptr0_cur", bus.cur_freq_o, 20);

    // Reset in WAIT_LOCK, then re-issue of the still-pending request.
    tick();
    lk_mode = LK_STUCK;
    issues0 = issue_total;
    acks0 = ack_total;
    drive(1, 8'd50, 1'b1);
    n = 0;
    while (issue_total == issues0 && n < 50) begin tick(); n++; end
    check("rstlk_issued", issue_total - issues0, 1);
    repeat (5) tick();
    check("rstlk_busy_pre", bus.busy_o, 1);
    rst_in = 1'b0;
    #1;
    check("rstlk_freq_valid", bus.freq_valid_o, 0);
    check("rstlk_freq_data",  bus.freq_data_o, 0);
    check("rstlk_ack",        bus.req_ack_o, 0);
    check("rstlk_cur",        bus.cur_freq_o, 0);
    check("rstlk_busy",       bus.busy_o, 1);
    lk_mode = LK_OFF;
    outstanding = 0;
    exp_freq_q.push_back(8'd50);
    repeat (3) tick();
    rst_in = 1'b1;
    repeat (3) tick();
    check("rstlk_no_issue_unlocked", issue_total - issues0, 1);
    lk_mode = LK_DROP;
    wait_acks(acks0 + 1, 200, "rstlk");
    check("rstlk_reissued", issue_total - issues0, 2);
    check("rstlk_cur_after", bus.cur_freq_o, 50);

`ifdef DFS_ARB_TIMEOUT_EN
    tick();
    lk_mode = LK_STUCK;
    acks0 = ack_total;
    drive(2, 8'd99, 1'b1);
    wait_acks(acks0 + 1, LT + 300, "tmo");
    check("tmo_err", bus.err_o, 1);
    check("tmo_err_cycle", err_rise_cyc - last_issue_cyc, LT + 2);
    check("tmo_ack_lat", last_ack_cyc - last_issue_cyc, LT + 3);
    check("tmo_cur_unchanged", bus.cur_freq_o, 50);
`else
    check("err_tied_low", bus.err_o, 0);
`endif

    check("exp_freq_drained", exp_freq_q.size(), 0);
    check("exp_ack_drained", exp_ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dfs_freq_arbiter.md
Name: dfs_freq_arbiter

Overview:
- Shares the single DFS frequency-request port (8-bit index plus valid) between N_REQ requesters, e.g. per-tile DVFS governors.
- Arbitrates round-robin and issues one request at a time to the clock manager.
- Sequences each change through MMCM unlock/relock plus a settle interval, then acknowledges the granted requester.
- Sits between the tile DVFS controllers and the clock manager, in the clk_in domain.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- FREQ_W, 8, width of a frequency index; must match the clock manager's freq_data_in.
- RESET_FREQ, 0, index reported on cur_freq_o after reset, before any change is applied.
- UNLOCK_WINDOW, 64, cycles to wait for mmcm_locked_i to fall after issuing a request.
- SETTLE_CYCLES, 16, cycles to wait after lock is confirmed before acknowledging.
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK; used only with DFS_ARB_TIMEOUT_EN.

Ports:
- clk_in  in  1  reference clock; the arbiter runs on the un-scaled input clock.
- rst_in  in  1  asynchronous, active-low reset.
- req_valid_i  in  N_REQ  per-requester request; level, held until the matching ack.
- req_freq_i  in  N_REQ*FREQ_W  requested index; requester r uses slice [r*FREQ_W +: FREQ_W]; stable while valid.
- req_ack_o  out  N_REQ  one-cycle pulse to the served requester.
- freq_data_o  out  FREQ_W  index driven to the clock manager's freq_data_in.
- freq_valid_o  out  1  one-cycle pulse to the clock manager's freq_valid_in.
- mmcm_locked_i  in  1  lock status from the clock manager.
- cur_freq_o  out  FREQ_W  last applied index.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky lock-timeout flag; tied 0 without DFS_ARB_TIMEOUT_EN.

Behaviour:
- Reset values (async on rst_in low): state INIT, freq_valid_o 0, freq_data_o 0, req_ack_o 0, cur_freq_o RESET_FREQ, rr pointer 0, err_o 0, all counters 0.
- INIT: busy_o 1. Go to IDLE on the first cycle mmcm_locked_i is 1. No grants in INIT.
- IDLE: if any req_valid_i is set, grant the first set bit at or after ptr, searching upward modulo N_REQ. Latch grant index g and its data.
  - Set ptr to (g+1) mod N_REQ on every grant.
  - If the data equals cur_freq_o: go to ACK (no DFS issue). Acknowledged 2 cycles after the grant cycle.
  - Otherwise: go to ISSUE.
- ISSUE: freq_data_o is the latched data, held until the next issue. freq_valid_o is 1 for exactly this cycle. Then WAIT_UNLOCK with counter cleared.
- WAIT_UNLOCK:
  - mmcm_locked_i 0: go to WAIT_LOCK.
  - Counter reaches UNLOCK_WINDOW-1 with lock still 1: go to SETTLE. This covers a glitchless dual-MMCM switch.
- WAIT_LOCK: mmcm_locked_i 1: go to SETTLE with counter cleared.
- SETTLE: count SETTLE_CYCLES, then update cur_freq_o to the latched data and go to ACK.
- ACK: req_ack_o[g] is 1 for one cycle, then IDLE. No new grant in the ACK cycle.
- Requester drops req_valid_i mid-sequence: the sequence completes and the ack is still pulsed; the requester ignores it.
- Loss of lock while in IDLE: go to INIT and block grants until relock. cur_freq_o is unchanged.
- Simultaneous requests: round-robin order only; no starvation. The worst-case wait is N_REQ-1 full sequences.
- All counters saturate. They are wide enough for the max of the three cycle parameters.

Optional Feature:
- Macro: DFS_ARB_TIMEOUT_EN.
- Defined:
  - WAIT_LOCK counts cycles. On reaching LOCK_TIMEOUT-1, err_o sets (sticky until reset) and the state goes to ACK.
  - cur_freq_o is not updated on a timeout.
- Undefined:
  - WAIT_LOCK waits indefinitely.
  - err_o is tied 0 and no timeout counter is instantiated.

Decomposition:
- Package dfs_arb_pkg holds:
  - enum state_t {INIT, IDLE, ISSUE, WAIT_UNLOCK, WAIT_LOCK, SETTLE, ACK};
  - localparam FREQ_W_DEF = 8;
  - function clog2_sat for counter widths.
- Sub-module dfs_rr_arbiter (combinational grant from req and ptr, with a one-hot output and an index output). It is reused by future DVFS sharing blocks.
- The FSM, counters and datapath live in dfs_freq_arbiter.

Test Plan:
- Reset, hold locked 0 for 10 cycles, then 1. Assert req 0 = 8'd12 -> no grant before lock. Exactly one freq_valid_o pulse with data 12. Model drops lock for 20 cycles. Ack 0 arrives SETTLE_CYCLES+1 cycles after relock. cur_freq_o = 12.
- Requesters 0..3 all valid at once with values 3, 5, 7, 9 -> issue order 0, 1, 2, 3 with matching data. Each ack precedes the next freq_valid_o. ptr ends at 0.
- Req 2 asks for 12 while cur_freq_o = 12 -> ack 2 cycles after the grant. freq_valid_o stays 0.
- Lock never drops after issue -> SETTLE entered after UNLOCK_WINDOW cycles. Ack follows SETTLE_CYCLES later.
- Assert rst_in low during WAIT_LOCK -> all outputs return to reset values immediately. After rst_in is released, a pending request is re-issued once lock is seen.
- With DFS_ARB_TIMEOUT_EN and lock held 0 after issue -> err_o rises at LOCK_TIMEOUT. Ack pulses. cur_freq_o is unchanged.
